fp16_max_reducer: RTL

FP16_MAX_REDUCER -- requirements
Module: fp16_max_reducer

---
 rtl/fp16_max_reducer.sv | 99 +++++++++
 1 files changed

// File: rtl/fp16_max_reducer.sv
// Streaming fp16 max/argmax over groups of up to WIN elements, 1-cycle result latency.
// Optional fused ReLU on out_max when MAXRED_RELU_EN is defined.
//
// state | meaning
// IDLE  | waiting for the first element of a group
// ACC   | accumulating; running max/idx/cnt valid
// OUT   | result held on out_* until consumer accepts
module fp16_max_reducer #(
  parameter int WIN   = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W-1:0] out_cnt,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } stateT;

  // cnt before the increment equals WIN-1 exactly when the WIN-th element arrives
  localparam logic [IDX_W-1:0] LastCnt = IDX_W'(WIN - 1);

  stateT            state, stateNext;
  logic [15:0]      maxReg;
  logic [IDX_W-1:0] idxReg;
  logic [IDX_W-1:0] cntReg;
  logic             inXfer;

  // Strict "a beats b": sign first (+0 beats -0), then magnitude by sign.
  function automatic logic fpGreater(input logic [15:0] a, input logic [15:0] b);
    logic res;
    if (a[15] != b[15])
      res = b[15];
    else if (!a[15])
      res = (a[14:0] > b[14:0]);
    else
      res = (a[14:0] < b[14:0]);
    return res;
  endfunction

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign inXfer    = in_valid && in_ready;
  assign out_idx   = idxReg;
  assign out_cnt   = cntReg;

`ifdef MAXRED_RELU_EN
  assign out_max = maxReg[15] ? 16'h0000 : maxReg;
`else
  assign out_max = maxReg;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (inXfer) stateNext = in_last ? OUT : ACC;
      ACC:  if (inXfer && (in_last || cntReg == LastCnt)) stateNext = OUT;
      OUT:  if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxReg <= 16'h0000;
      idxReg <= '0;
      cntReg <= '0;
    end else if (inXfer) begin
      if (state == IDLE) begin
        maxReg <= in_data;
        idxReg <= '0;
        cntReg <= IDX_W'(1);
      end else begin
        if (fpGreater(in_data, maxReg)) begin
          maxReg <= in_data;
          idxReg <= cntReg;
        end
        cntReg <= cntReg + IDX_W'(1);
      end
    end
  end

endmodule
